// File: rtl/mem_wb_stage_pkg.sv
// Shared types for the MEM->WB stage: writeback payload, writeback source
// select encoding, and the occupancy states of the stage buffer.
package mem_wb_stage_pkg;

  localparam int unsigned MW_WORD_W  = 32;
  localparam int unsigned MW_RADDR_W = 5;
  localparam int unsigned MW_IMM_W   = 16;

  // Writeback payload carried from MEM to WB
  typedef struct packed {
    logic                  jal;
    logic                  lui;
    logic                  memtoreg;
    logic                  regwr;
    logic [MW_WORD_W-1:0]  pcplus4;
    logic [MW_WORD_W-1:0]  aluout;
    logic [MW_WORD_W-1:0]  dload;
    logic [MW_IMM_W-1:0]   imm16;
    logic [MW_RADDR_W-1:0] wsel;
  } mw_pkt_t;

  // Writeback value source
  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_LUI = 2'd2,
    WB_SEL_PC  = 2'd3
  } wb_sel_e;

  // Occupancy encoded as {main_v, skid_v}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } stall_state_e;

  // Writeback source priority: jal over lui over memtoreg over ALU
  function automatic wb_sel_e wb_sel(input logic jal, input logic lui,
                                     input logic memtoreg);
    wb_sel_e sel;
    if (jal)           sel = WB_SEL_PC;
    else if (lui)      sel = WB_SEL_LUI;
    else if (memtoreg) sel = WB_SEL_MEM;
    else               sel = WB_SEL_ALU;
    return sel;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Handshake, payload and writeback-port bundle between MEM->WB stage and its neighbours.
interface mem_wb_stage_if #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 16
);
  import mem_wb_stage_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  mw_pkt_t            in_pkt;
  logic               out_valid;
  logic               out_ready;
  mw_pkt_t            out_pkt;
  logic               wb_wen;
  logic [RADDR_W-1:0] wb_wsel;
  logic [WORD_W-1:0]  wb_wdat;
  logic [CNT_W-1:0]   stall_cnt;

  // Stage side
  modport mw (
    input  flush, in_valid, in_pkt, out_ready,
    output in_ready, out_valid, out_pkt, wb_wen, wb_wsel, wb_wdat, stall_cnt
  );

  // Environment side (upstream MEM, downstream WB/RF)
  modport tb (
    output flush, in_valid, in_pkt, out_ready,
    input  in_ready, out_valid, out_pkt, wb_wen, wb_wsel, wb_wdat, stall_cnt
  );

endinterface

// File: rtl/mem_wb_stage_wb_mux.sv
// Writeback value select; also usable by the forwarding unit.
module mem_wb_stage_wb_mux
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic                 i_jal,
  input  logic                 i_lui,
  input  logic                 i_memtoreg,
  input  logic [MW_WORD_W-1:0] i_pcplus4,
  input  logic [MW_WORD_W-1:0] i_aluout,
  input  logic [MW_WORD_W-1:0] i_dload,
  input  logic [MW_IMM_W-1:0]  i_imm16,
  output logic [WORD_W-1:0]    o_wdat_c
);

  logic [MW_WORD_W-1:0] w_lui_val;
  wb_sel_e              w_sel;

  // lui places the immediate in the upper half; wider words zero-extend
  assign w_lui_val = {i_imm16, {(MW_WORD_W - MW_IMM_W){1'b0}}};
  assign w_sel     = wb_sel(i_jal, i_lui, i_memtoreg);

  // Select writeback source by priority
  always_comb begin
    o_wdat_c = '0;
    case (w_sel)
      WB_SEL_PC:  o_wdat_c = WORD_W'(i_pcplus4);
      WB_SEL_LUI: o_wdat_c = WORD_W'(w_lui_val);
      WB_SEL_MEM: o_wdat_c = WORD_W'(i_dload);
      default:    o_wdat_c = WORD_W'(i_aluout);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: one-cycle registered payload with optional skid
// entry, synchronous flush, writeback value precompute and stall counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mem_wb_stage_if.mw     bus
);

  stall_state_e       r_state;
  mw_pkt_t            r_main;
  mw_pkt_t            r_skid;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_retire;
  logic               w_stall;
  logic [WORD_W-1:0]  w_wdat;

  // Handshake qualifiers; with a skid entry in_ready depends only on state
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_ready  = (SKID != 0) ? (r_state != ST_SKID)
                                   : ((r_state == ST_EMPTY) || bus.out_ready);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_retire    = w_out_valid && bus.out_ready;
  assign w_stall     = w_out_valid && !bus.out_ready;

  // Occupancy FSM, payload registers and saturating stall counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (bus.flush) begin
        r_state <= ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_accept) begin
              r_main  <= bus.in_pkt;
              r_state <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (w_accept) begin
              if (w_retire || (SKID == 0)) begin
                r_main <= bus.in_pkt;
              end else begin
                r_skid  <= bus.in_pkt;
                r_state <= ST_SKID;
              end
            end else if (w_retire) begin
              r_state <= ST_EMPTY;
            end
          end
          ST_SKID: begin
            if (w_retire) begin
              r_main  <= r_skid;
              r_state <= ST_FULL;
            end
          end
          default: r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  // Writeback value from the head entry
  mem_wb_stage_wb_mux #(
    .WORD_W (WORD_W)
  ) u_wb_mux (
    .i_jal      (r_main.jal),
    .i_lui      (r_main.lui),
    .i_memtoreg (r_main.memtoreg),
    .i_pcplus4  (r_main.pcplus4),
    .i_aluout   (r_main.aluout),
    .i_dload    (r_main.dload),
    .i_imm16    (r_main.imm16),
    .o_wdat_c   (w_wdat)
  );

  // Output drive; register 0 is never written
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pkt   = r_main;
  assign bus.wb_wen    = w_retire && r_main.regwr && (r_main.wsel != '0);
  assign bus.wb_wsel   = RADDR_W'(r_main.wsel);
  assign bus.wb_wdat   = w_wdat;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: SKID=1 and SKID=0 instances side by side, a
// scoreboard on each, a writeback vector table and cycle-level sequences.
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  mem_wb_stage_if #(.WORD_W(32), .RADDR_W(5), .CNT_W(16)) if_s1 ();
  mem_wb_stage_if #(.WORD_W(32), .RADDR_W(5), .CNT_W(16)) if_s0 ();

  mem_wb_stage #(.WORD_W(32), .RADDR_W(5), .SKID(1), .CNT_W(16)) u_dut_s1 (
    .i_clk (clk), .i_rst (rst), .bus (if_s1.mw)
  );
  mem_wb_stage #(.WORD_W(32), .RADDR_W(5), .SKID(0), .CNT_W(16)) u_dut_s0 (
    .i_clk (clk), .i_rst (rst), .bus (if_s0.mw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mw_pkt_t q1[$];
  mw_pkt_t q0[$];

  typedef struct {
    mw_pkt_t     p;
    logic [31:0] e_wdat;
    logic        e_wen;
  } vec_t;

  typedef struct {
    logic iv;
    int   pi;
    logic ordy;
    logic fl;
    logic e_irdy;
    logic e_ov;
    int   e_head;
  } cyc_t;

  localparam int NV = 7;
  vec_t    vt[NV];
  cyc_t    seq[$];
  mw_pkt_t bp[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic e);
    chk(nm, 128'(a), 128'(e));
  endtask

  task automatic chkw(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk(nm, 128'(a), 128'(e));
  endtask

  task automatic chkp(input string nm, input mw_pkt_t a, input mw_pkt_t e);
    chk(nm, 128'(a), 128'(e));
  endtask

  function automatic mw_pkt_t mk(input logic jal, input logic lui, input logic mtr,
                                 input logic rw, input logic [31:0] pc,
                                 input logic [31:0] alu, input logic [31:0] dl,
                                 input logic [15:0] imm, input logic [4:0] ws);
    mw_pkt_t p;
    p.jal = jal; p.lui = lui; p.memtoreg = mtr; p.regwr = rw;
    p.pcplus4 = pc; p.aluout = alu; p.dload = dl; p.imm16 = imm; p.wsel = ws;
    return p;
  endfunction

  // Reference writeback value
  function automatic logic [31:0] model_wdat(input mw_pkt_t p);
    if (p.jal) return p.pcplus4;
    if (p.lui) return {p.imm16, 16'h0000};
    if (p.memtoreg) return p.dload;
    return p.aluout;
  endfunction

  task automatic drv(input int d, input logic iv, input mw_pkt_t p,
                     input logic ordy, input logic fl);
    if (d == 1) begin
      if_s1.in_valid = iv; if_s1.in_pkt = p; if_s1.out_ready = ordy; if_s1.flush = fl;
    end else begin
      if_s0.in_valid = iv; if_s0.in_pkt = p; if_s0.out_ready = ordy; if_s0.flush = fl;
    end
  endtask

  task automatic idle_all();
    drv(1, 1'b0, '0, 1'b1, 1'b0);
    drv(0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  // Scoreboard step for one DUT, evaluated between clock edges
  task automatic sb_mon(input int d);
    logic ov, ordy, iv, irdy, fl, wen;
    mw_pkt_t op, ip, e;
    logic [31:0] wdat;
    logic [4:0]  ws;
    int qs;
    if (d == 1) begin
      ov = if_s1.out_valid; ordy = if_s1.out_ready; iv = if_s1.in_valid;
      irdy = if_s1.in_ready; fl = if_s1.flush; wen = if_s1.wb_wen;
      op = if_s1.out_pkt; ip = if_s1.in_pkt; wdat = if_s1.wb_wdat; ws = if_s1.wb_wsel;
      qs = q1.size();
    end else begin
      ov = if_s0.out_valid; ordy = if_s0.out_ready; iv = if_s0.in_valid;
      irdy = if_s0.in_ready; fl = if_s0.flush; wen = if_s0.wb_wen;
      op = if_s0.out_pkt; ip = if_s0.in_pkt; wdat = if_s0.wb_wdat; ws = if_s0.wb_wsel;
      qs = q0.size();
    end
    if (ov && ordy) begin
      if (qs == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL sb%0d_unexpected: retired pkt 0x%0h, want nothing", d, op);
      end else begin
        if (d == 1) e = q1.pop_front();
        else        e = q0.pop_front();
        chkp($sformatf("sb%0d_pkt", d), op, e);
        chkw($sformatf("sb%0d_wdat", d), wdat, model_wdat(e));
        chk1($sformatf("sb%0d_wen", d), wen, e.regwr && (e.wsel != 5'd0));
        if (e.regwr && (e.wsel != 5'd0))
          chkw($sformatf("sb%0d_wsel", d), 32'(ws), 32'(e.wsel));
      end
    end
    if (fl) begin
      if (d == 1) q1.delete();
      else        q0.delete();
    end else if (iv && irdy) begin
      if (d == 1) q1.push_back(ip);
      else        q0.push_back(ip);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      q0.delete();
    end else begin
      sb_mon(1);
      sb_mon(0);
    end
  end

  function automatic void add(input logic iv, input int pi, input logic ordy,
                              input logic fl, input logic e_irdy, input logic e_ov,
                              input int e_head);
    cyc_t c;
    c.iv = iv; c.pi = pi; c.ordy = ordy; c.fl = fl;
    c.e_irdy = e_irdy; c.e_ov = e_ov; c.e_head = e_head;
    seq.push_back(c);
  endfunction

  // Apply the queued per-cycle sequence to one DUT and check handshake/head
  task automatic run_seq(input int d, input string tag);
    logic irdy, ov;
    mw_pkt_t op;
    for (int i = 0; i < seq.size(); i++) begin
      @(posedge clk); #1;
      drv(d, seq[i].iv, bp[seq[i].pi], seq[i].ordy, seq[i].fl);
      @(negedge clk);
      if (d == 1) begin irdy = if_s1.in_ready; ov = if_s1.out_valid; op = if_s1.out_pkt; end
      else        begin irdy = if_s0.in_ready; ov = if_s0.out_valid; op = if_s0.out_pkt; end
      chk1($sformatf("%s_c%0d_in_ready", tag, i), irdy, seq[i].e_irdy);
      chk1($sformatf("%s_c%0d_out_valid", tag, i), ov, seq[i].e_ov);
      if (seq[i].e_ov)
        chkw($sformatf("%s_c%0d_head", tag, i), op.aluout, bp[seq[i].e_head].aluout);
    end
    seq.delete();
    @(posedge clk); #1;
    drv(d, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;

    vt[0] = '{mk(1,1,1,1, 32'h404, 32'h1, 32'hCAFEF00D, 16'hBEEF, 5'd3), 32'h00000404, 1'b1};
    vt[1] = '{mk(0,1,1,1, 32'h404, 32'h1, 32'hCAFEF00D, 16'hBEEF, 5'd3), 32'hBEEF0000, 1'b1};
    vt[2] = '{mk(0,0,1,1, 32'h404, 32'h1, 32'hCAFEF00D, 16'hBEEF, 5'd4), 32'hCAFEF00D, 1'b1};
    vt[3] = '{mk(0,0,0,1, 32'h404, 32'h12345678, 32'hCAFEF00D, 16'hBEEF, 5'd5), 32'h12345678, 1'b1};
    vt[4] = '{mk(0,0,0,1, 32'h0, 32'h0000DEAD, 32'h0, 16'h0, 5'd0), 32'h0000DEAD, 1'b0};
    vt[5] = '{mk(0,0,0,0, 32'h0, 32'h00000077, 32'h0, 16'h0, 5'd31), 32'h00000077, 1'b0};
    vt[6] = '{mk(0,1,0,1, 32'h8, 32'h9, 32'hA, 16'h0001, 5'd31), 32'h00010000, 1'b1};

    for (int i = 0; i < 5; i++)
      bp[i] = mk(0,0,0,1, 32'h100 + 32'(i), 32'hA0 + 32'(i), 32'h0, 16'h0, 5'd9);

    // Reset state
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    chk1("rst_s1_out_valid", if_s1.out_valid, 1'b0);
    chk1("rst_s1_in_ready", if_s1.in_ready, 1'b1);
    chk1("rst_s1_wb_wen", if_s1.wb_wen, 1'b0);
    chkw("rst_s1_wb_wsel", 32'(if_s1.wb_wsel), 32'h0);
    chkw("rst_s1_wb_wdat", if_s1.wb_wdat, 32'h0);
    chkw("rst_s1_stall_cnt", 32'(if_s1.stall_cnt), 32'h0);
    chk1("rst_s0_out_valid", if_s0.out_valid, 1'b0);
    chk1("rst_s0_in_ready", if_s0.in_ready, 1'b1);
    #2 rst = 1'b0;

    // Back-to-back stream, full throughput
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        drv(1, 1'b1, mk(0,0,0,1, 32'h0, 32'h10 + 32'(i), 32'h0, 16'h0, 5'd8), 1'b1, 1'b0);
        drv(0, 1'b1, mk(0,0,0,1, 32'h0, 32'h10 + 32'(i), 32'h0, 16'h0, 5'd8), 1'b1, 1'b0);
      end else begin
        idle_all();
      end
      @(negedge clk);
      if (i > 0) begin
        chk1($sformatf("stream_s1_wen%0d", i), if_s1.wb_wen, 1'b1);
        chkw($sformatf("stream_s1_wdat%0d", i), if_s1.wb_wdat, 32'h10 + 32'(i - 1));
        chk1($sformatf("stream_s0_wen%0d", i), if_s0.wb_wen, 1'b1);
        chkw($sformatf("stream_s0_wdat%0d", i), if_s0.wb_wdat, 32'h10 + 32'(i - 1));
      end
    end
    @(negedge clk);
    chk1("stream_s1_drained", if_s1.out_valid, 1'b0);

    // Writeback mux priority and register-0 suppression
    for (int i = 0; i <= NV; i++) begin
      @(posedge clk); #1;
      if (i < NV) begin
        drv(1, 1'b1, vt[i].p, 1'b1, 1'b0);
        drv(0, 1'b1, vt[i].p, 1'b1, 1'b0);
      end else begin
        idle_all();
      end
      @(negedge clk);
      if (i > 0) begin
        chkw($sformatf("vec%0d_s1_wdat", i - 1), if_s1.wb_wdat, vt[i - 1].e_wdat);
        chk1($sformatf("vec%0d_s1_wen", i - 1), if_s1.wb_wen, vt[i - 1].e_wen);
        chkw($sformatf("vec%0d_s0_wdat", i - 1), if_s0.wb_wdat, vt[i - 1].e_wdat);
        chk1($sformatf("vec%0d_s0_wen", i - 1), if_s0.wb_wen, vt[i - 1].e_wen);
      end
    end

    // Backpressure with skid entry: A in main, B in skid, C held upstream
    add(1,0,0,0, 1,0,-1);
    add(1,1,0,0, 1,1,0);
    add(1,2,0,0, 0,1,0);
    add(1,2,0,0, 0,1,0);
    add(1,2,1,0, 0,1,0);
    add(1,2,1,0, 1,1,1);
    add(0,0,1,0, 1,1,2);
    add(0,0,1,0, 1,0,-1);
    run_seq(1, "bp_s1");

    // Backpressure without skid: in_ready follows out_ready when full
    add(1,0,0,0, 1,0,-1);
    add(1,1,0,0, 0,1,0);
    add(1,1,0,0, 0,1,0);
    add(1,1,0,0, 0,1,0);
    add(1,1,1,0, 1,1,0);
    add(1,2,1,0, 1,1,1);
    add(0,0,1,0, 1,1,2);
    add(0,0,1,0, 1,0,-1);
    run_seq(0, "bp_s0");

    // Flush while holding a skid entry, with C offered in the same cycle
    add(1,0,0,0, 1,0,-1);
    add(1,1,0,0, 1,1,0);
    add(1,2,0,1, 0,1,0);
    add(0,0,1,0, 1,0,-1);
    add(1,4,1,0, 1,0,-1);
    add(0,0,1,0, 1,1,4);
    add(0,0,1,0, 1,0,-1);
    run_seq(1, "flush_s1");

    // Flush with an acceptable incoming entry while the head retires
    add(1,0,0,0, 1,0,-1);
    add(1,3,1,1, 1,1,0);
    add(0,0,1,0, 1,0,-1);
    run_seq(0, "flush_s0");

    @(negedge clk);
    chkw("stall_s1_total", 32'(if_s1.stall_cnt), 32'd5);
    chkw("stall_s0_total", 32'(if_s0.stall_cnt), 32'd3);

    // Asynchronous reset mid-operation with both stages stalled
    @(posedge clk); #1;
    drv(1, 1'b1, bp[0], 1'b0, 1'b0);
    drv(0, 1'b1, bp[0], 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(1, 1'b1, bp[1], 1'b0, 1'b0);
    drv(0, 1'b1, bp[1], 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chkw("pre_rst_s1_stall", 32'(if_s1.stall_cnt), 32'd6);
    chkw("pre_rst_s0_stall", 32'(if_s0.stall_cnt), 32'd4);
    #2 rst = 1'b1;
    #1;
    chk1("midrst_s1_out_valid", if_s1.out_valid, 1'b0);
    chk1("midrst_s1_in_ready", if_s1.in_ready, 1'b1);
    chkw("midrst_s1_stall", 32'(if_s1.stall_cnt), 32'd0);
    chk1("midrst_s0_out_valid", if_s0.out_valid, 1'b0);
    chkw("midrst_s0_stall", 32'(if_s0.stall_cnt), 32'd0);
    idle_all();
    @(negedge clk);
    #2 rst = 1'b0;

    // Normal operation after reset
    @(posedge clk); #1;
    drv(1, 1'b1, bp[4], 1'b1, 1'b0);
    drv(0, 1'b1, bp[4], 1'b1, 1'b0);
    @(posedge clk); #1;
    idle_all();
    @(negedge clk);
    chkw("postrst_s1_wdat", if_s1.wb_wdat, 32'hA4);
    chkw("postrst_s0_wdat", if_s0.wb_wdat, 32'hA4);
    repeat (3) @(negedge clk);

    chkw("sb_s1_leftover", 32'(q1.size()), 32'd0);
    chkw("sb_s0_leftover", 32'(q0.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
